// File: rtl/asrv32_memoryaccess_pkg.sv
// asrv32_memoryaccess_pkg
//   Shared constants for the memory-access stage: one-hot opcode layout, load/store funct3
//   encodings, and the access-size decode used by the lane aligner.
//   No ports (package).
package asrv32_memoryaccess_pkg;

  // One-hot opcode vector from the ALU stage; each index is one instruction class.
  localparam int unsigned OpcodeWidth = 11;
  localparam int unsigned OpRtype     = 0;
  localparam int unsigned OpItype     = 1;
  localparam int unsigned OpLoad      = 2;
  localparam int unsigned OpStore     = 3;
  localparam int unsigned OpBranch    = 4;
  localparam int unsigned OpJal       = 5;
  localparam int unsigned OpJalr      = 6;
  localparam int unsigned OpLui       = 7;
  localparam int unsigned OpAuipc     = 8;
  localparam int unsigned OpSystem    = 9;
  localparam int unsigned OpFence     = 10;

  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;
  localparam logic [2:0] Funct3Sb  = 3'b000;
  localparam logic [2:0] Funct3Sh  = 3'b001;
  localparam logic [2:0] Funct3Sw  = 3'b010;

  typedef enum logic [1:0] {
    SizeByte,
    SizeHalf,
    SizeWord
  } size_e;

  // Any funct3 that is not a defined byte/half encoding falls back to word size.
  function automatic size_e decode_size(input logic is_store, input logic [2:0] funct3);
    size_e size;
    size = SizeWord;
    if (is_store) begin
      if (funct3 == Funct3Sb) size = SizeByte;
      else if (funct3 == Funct3Sh) size = SizeHalf;
    end else begin
      if (funct3 == Funct3Lb || funct3 == Funct3Lbu) size = SizeByte;
      else if (funct3 == Funct3Lh || funct3 == Funct3Lhu) size = SizeHalf;
    end
    return size;
  endfunction

endpackage

// File: rtl/asrv32_memoryaccess_lsu_align.sv
// asrv32_memoryaccess_lsu_align
//   Combinational lane aligner for the memory-access stage.
//   Request side : req_addr[1:0], req_funct3, req_store, store_data
//                  -> sel (byte enables), wb_data (lane-replicated store data), misaligned
//   Response side: rsp_addr[1:0], rsp_funct3, rsp_data -> load_data (extracted, extended)
module asrv32_memoryaccess_lsu_align
  import asrv32_memoryaccess_pkg::*;
(
  input  logic [1:0]  req_addr,
  input  logic [2:0]  req_funct3,
  input  logic        req_store,
  input  logic [31:0] store_data,
  output logic [3:0]  sel,
  output logic [31:0] wb_data,
  output logic        misaligned,
  input  logic [1:0]  rsp_addr,
  input  logic [2:0]  rsp_funct3,
  input  logic [31:0] rsp_data,
  output logic [31:0] load_data
);

  size_e       req_size;
  size_e       rsp_size;
  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;
  logic        rsp_signed;

  assign req_size = decode_size(req_store, req_funct3);
  assign rsp_size = decode_size(1'b0, rsp_funct3);

  always_comb begin
    sel        = 4'hF;
    wb_data    = store_data;
    misaligned = 1'b0;
    unique case (req_size)
      SizeByte: begin
        sel     = 4'b0001 << req_addr;
        wb_data = {4{store_data[7:0]}};
      end
      SizeHalf: begin
        sel        = req_addr[1] ? 4'b1100 : 4'b0011;
        wb_data    = {2{store_data[15:0]}};
        misaligned = req_addr[0];
      end
      default: begin
        misaligned = |req_addr;
      end
    endcase
  end

  // funct3[2] distinguishes LBU/LHU from their sign-extending counterparts.
  assign rsp_signed = ~rsp_funct3[2];
  assign rsp_half   = rsp_addr[1] ? rsp_data[31:16] : rsp_data[15:0];

  always_comb begin
    rsp_byte = rsp_data[7:0];
    unique case (rsp_addr)
      2'd0: rsp_byte = rsp_data[7:0];
      2'd1: rsp_byte = rsp_data[15:8];
      2'd2: rsp_byte = rsp_data[23:16];
      2'd3: rsp_byte = rsp_data[31:24];
    endcase
  end

  always_comb begin
    load_data = rsp_data;
    unique case (rsp_size)
      SizeByte: load_data = {{24{rsp_signed & rsp_byte[7]}}, rsp_byte};
      SizeHalf: load_data = {{16{rsp_signed & rsp_half[15]}}, rsp_half};
      default:  load_data = rsp_data;
    endcase
  end

endmodule

// File: rtl/asrv32_memoryaccess.sv
// asrv32_memoryaccess
//   Memory-access pipeline stage between ALU and writeback. Issues loads/stores over a
//   pipelined Wishbone master port, aligns/extends load data, and registers every field that
//   writeback consumes. Holds the upstream pipeline while a bus cycle is outstanding.
// Ports
//   i_clk, i_rst                        clock, synchronous active-high reset
//   i_opcode..i_rd_data, i_ce           instruction fields and valid from the ALU stage
//   i_stall, i_flush                    backpressure / flush from writeback
//   o_opcode..o_y, o_load_data          registered fields to writeback
//   o_misaligned, o_ce                  address-alignment fault, next-stage valid
//   o_stall, o_flush                    backpressure / flush to upstream
//   o_wb_*, i_wb_*                      pipelined Wishbone master
module asrv32_memoryaccess
  import asrv32_memoryaccess_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [OpcodeWidth-1:0] i_opcode,
  input  logic [2:0]             i_funct3,
  input  logic [31:0]            i_y,
  input  logic [31:0]            i_rs2_data,
  input  logic [31:0]            i_pc,
  input  logic                   i_wr_rd_en,
  input  logic [4:0]             i_rd_addr,
  input  logic [31:0]            i_rd_data,
  input  logic                   i_ce,
  input  logic                   i_stall,
  input  logic                   i_flush,
  output logic [OpcodeWidth-1:0] o_opcode,
  output logic [2:0]             o_funct3,
  output logic [31:0]            o_pc,
  output logic                   o_wr_rd_en,
  output logic [4:0]             o_rd_addr,
  output logic [31:0]            o_rd_data,
  output logic [31:0]            o_y,
  output logic [31:0]            o_load_data,
  output logic                   o_misaligned,
  output logic                   o_ce,
  output logic                   o_stall,
  output logic                   o_flush,
  output logic                   o_wb_cyc,
  output logic                   o_wb_stb,
  output logic                   o_wb_we,
  output logic [31:0]            o_wb_addr,
  output logic [31:0]            o_wb_data,
  output logic [3:0]             o_wb_sel,
  input  logic                   i_wb_ack,
  input  logic                   i_wb_stall,
  input  logic [31:0]            i_wb_data
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        flush_q, flush_d;
  logic        ack_seen_q, ack_seen_d;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        accept;
  logic        issue;
  logic        ack;
  logic        done;

  logic [3:0]  req_sel;
  logic [31:0] req_data;
  logic        req_misaligned;
  logic [31:0] rsp_load_data;

  assign is_load  = i_opcode[OpLoad];
  assign is_store = i_opcode[OpStore];
  assign is_mem   = is_load | is_store;

  assign o_stall  = i_stall | (state_q == StBusy);
  assign o_flush  = i_flush;

  assign accept   = i_ce & ~o_stall & ~i_flush;
  assign issue    = accept & is_mem & ~req_misaligned;
  // Only an ack inside our own cycle counts; stray acks after a reset are dropped.
  assign ack      = o_wb_cyc & i_wb_ack;
  // An ack that lands while writeback stalls is remembered and retired once the stall lifts.
  assign done     = (state_q == StBusy) & (ack | ack_seen_q) & ~i_stall;

  asrv32_memoryaccess_lsu_align u_align (
    .req_addr   (i_y[1:0]),
    .req_funct3 (i_funct3),
    .req_store  (is_store),
    .store_data (i_rs2_data),
    .sel        (req_sel),
    .wb_data    (req_data),
    .misaligned (req_misaligned),
    .rsp_addr   (o_y[1:0]),
    .rsp_funct3 (o_funct3),
    .rsp_data   (i_wb_data),
    .load_data  (rsp_load_data)
  );

  always_comb begin
    state_d    = state_q;
    flush_d    = flush_q;
    ack_seen_d = ack_seen_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          state_d    = StBusy;
          flush_d    = 1'b0;
          ack_seen_d = 1'b0;
        end
      end
      StBusy: begin
        if (i_flush) flush_d = 1'b1;
        if (ack)     ack_seen_d = 1'b1;
        if (done) begin
          state_d    = StIdle;
          flush_d    = 1'b0;
          ack_seen_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      flush_q    <= 1'b0;
      ack_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      ack_seen_q <= ack_seen_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_opcode     <= '0;
      o_funct3     <= '0;
      o_pc         <= PC_RESET;
      o_wr_rd_en   <= 1'b0;
      o_rd_addr    <= '0;
      o_rd_data    <= '0;
      o_y          <= '0;
      o_load_data  <= '0;
      o_misaligned <= 1'b0;
      o_ce         <= 1'b0;
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_addr    <= '0;
      o_wb_data    <= '0;
      o_wb_sel     <= '0;
    end else if (state_q == StIdle) begin
      if (accept) begin
        o_opcode     <= i_opcode;
        o_funct3     <= i_funct3;
        o_pc         <= i_pc;
        o_wr_rd_en   <= i_wr_rd_en;
        o_rd_addr    <= i_rd_addr;
        o_rd_data    <= i_rd_data;
        o_y          <= i_y;
        o_misaligned <= is_mem & req_misaligned;
        if (issue) begin
          o_wb_cyc  <= 1'b1;
          o_wb_stb  <= 1'b1;
          o_wb_we   <= is_store;
          o_wb_addr <= {i_y[31:2], 2'b00};
          o_wb_sel  <= req_sel;
          o_wb_data <= req_data;
          o_ce      <= 1'b0;
        end else begin
          // Non-memory ops and misaligned accesses retire without touching the bus.
          o_ce <= 1'b1;
        end
      end else if (i_flush || !i_stall) begin
        o_ce <= 1'b0;
      end
    end else begin
      if (o_wb_stb && !i_wb_stall) o_wb_stb <= 1'b0;
      if (ack) begin
        o_wb_cyc <= 1'b0;
        o_wb_stb <= 1'b0;
        if (o_opcode[OpLoad]) o_load_data <= rsp_load_data;
      end
      // A flush during the bus cycle lets the cycle finish but discards the result.
      if (done) o_ce <= ~(flush_q | i_flush);
    end
  end

endmodule

// File: tb/tb_asrv32_memoryaccess.sv
// tb_asrv32_memoryaccess
//   Scoreboard bench: stimulus pushes expected bus requests and writeback results into queues;
//   a monitor pops and compares whenever the DUT presents a request or a valid result.
//   A small Wishbone slave answers requests with programmable stall and ack delay.
module tb_asrv32_memoryaccess;
  import asrv32_memoryaccess_pkg::*;

  localparam logic [31:0] PcReset = 32'h0000_1000;

  logic                   i_clk;
  logic                   i_rst;
  logic [OpcodeWidth-1:0] i_opcode;
  logic [2:0]             i_funct3;
  logic [31:0]            i_y;
  logic [31:0]            i_rs2_data;
  logic [31:0]            i_pc;
  logic                   i_wr_rd_en;
  logic [4:0]             i_rd_addr;
  logic [31:0]            i_rd_data;
  logic                   i_ce;
  logic                   i_stall;
  logic                   i_flush;
  logic [OpcodeWidth-1:0] o_opcode;
  logic [2:0]             o_funct3;
  logic [31:0]            o_pc;
  logic                   o_wr_rd_en;
  logic [4:0]             o_rd_addr;
  logic [31:0]            o_rd_data;
  logic [31:0]            o_y;
  logic [31:0]            o_load_data;
  logic                   o_misaligned;
  logic                   o_ce;
  logic                   o_stall;
  logic                   o_flush;
  logic                   o_wb_cyc;
  logic                   o_wb_stb;
  logic                   o_wb_we;
  logic [31:0]            o_wb_addr;
  logic [31:0]            o_wb_data;
  logic [3:0]             o_wb_sel;
  logic                   i_wb_ack;
  logic                   i_wb_stall;
  logic [31:0]            i_wb_data;

  asrv32_memoryaccess #(.PC_RESET(PcReset)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct3(i_funct3), .i_y(i_y),
    .i_rs2_data(i_rs2_data), .i_pc(i_pc), .i_wr_rd_en(i_wr_rd_en), .i_rd_addr(i_rd_addr),
    .i_rd_data(i_rd_data), .i_ce(i_ce), .i_stall(i_stall), .i_flush(i_flush),
    .o_opcode(o_opcode), .o_funct3(o_funct3), .o_pc(o_pc), .o_wr_rd_en(o_wr_rd_en),
    .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_y(o_y), .o_load_data(o_load_data),
    .o_misaligned(o_misaligned), .o_ce(o_ce), .o_stall(o_stall), .o_flush(o_flush),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack),
    .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic        chk_data;
  } bus_exp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        misaligned;
    logic [31:0] load_data;
    logic        chk_ld;
  } res_exp_t;

  bus_exp_t bus_q[$];
  res_exp_t res_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Slave configuration, set by stimulus before each transaction.
  int          slv_stall = 0;
  int          slv_wait  = 1;
  logic [31:0] slv_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] data, input logic chk);
    bus_exp_t e;
    e.we = we; e.addr = addr; e.sel = sel; e.data = data; e.chk_data = chk;
    bus_q.push_back(e);
  endtask

  task automatic exp_res(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] rdd,
                         input logic mis, input logic [31:0] ld, input logic chk);
    res_exp_t e;
    e.pc = pc; e.rd_addr = rd; e.rd_data = rdd; e.misaligned = mis;
    e.load_data = ld; e.chk_ld = chk;
    res_q.push_back(e);
  endtask

  // Drives one instruction for a single accept edge; returns one cycle after that edge.
  task automatic issue(input int op, input logic [2:0] f3, input logic [31:0] y,
                       input logic [31:0] rs2, input logic [31:0] pc, input logic [4:0] rd,
                       input logic [31:0] rdd);
    i_opcode     = '0;
    i_opcode[op] = 1'b1;
    i_funct3     = f3;
    i_y          = y;
    i_rs2_data   = rs2;
    i_pc         = pc;
    i_rd_addr    = rd;
    i_rd_data    = rdd;
    i_wr_rd_en   = (op != OpStore);
    i_ce         = 1'b1;
    tick();
    i_ce         = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (o_stall && n < 50) begin
      tick();
      n++;
    end
    if (o_stall) begin
      n_checks++;
      n_fail++;
      $display("FAIL stall_timeout: o_stall=1 after 50 cycles, expected 0");
    end
  endtask

  // Monitor: compares every accepted bus request and every retired result.
  initial begin : monitor
    bus_exp_t be;
    res_exp_t re;
    forever begin
      @(negedge i_clk);
      if (!i_rst && o_wb_cyc && o_wb_stb && !i_wb_stall) begin
        if (bus_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL bus_req: got request addr %h sel %h, expected none", o_wb_addr,
                   o_wb_sel);
        end else begin
          be = bus_q.pop_front();
          check("bus_we", 32'(o_wb_we), 32'(be.we));
          check("bus_addr", o_wb_addr, be.addr);
          check("bus_sel", 32'(o_wb_sel), 32'(be.sel));
          if (be.chk_data) check("bus_data", o_wb_data, be.data);
        end
      end
      if (o_ce && !i_stall) begin
        if (res_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL result: got o_ce=1 pc %h, expected no result", o_pc);
        end else begin
          re = res_q.pop_front();
          check("res_pc", o_pc, re.pc);
          check("res_rd_addr", 32'(o_rd_addr), 32'(re.rd_addr));
          check("res_rd_data", o_rd_data, re.rd_data);
          check("res_misaligned", 32'(o_misaligned), 32'(re.misaligned));
          if (re.chk_ld) check("res_load_data", o_load_data, re.load_data);
        end
      end
    end
  end

  // Wishbone slave: stalls a new request slv_stall cycles, acks slv_wait+1 cycles after accept.
  bit acc_seen;
  bit req_seen;
  bit counting;
  int stall_left;
  int ack_cnt;

  initial begin : slave
    i_wb_ack   = 1'b0;
    i_wb_stall = 1'b0;
    i_wb_data  = 32'h5A5A_5A5A;
    req_seen   = 1'b0;
    counting   = 1'b0;
    stall_left = 0;
    ack_cnt    = 0;
    forever begin
      @(negedge i_clk);
      acc_seen = o_wb_cyc && o_wb_stb && !i_wb_stall;
      @(posedge i_clk);
      #1;
      i_wb_ack  = 1'b0;
      i_wb_data = 32'h5A5A_5A5A;
      if (acc_seen) begin
        counting = 1'b1;
        ack_cnt  = slv_wait;
      end
      if (counting) begin
        if (ack_cnt == 0) begin
          i_wb_ack  = 1'b1;
          i_wb_data = slv_rdata;
          counting  = 1'b0;
        end else begin
          ack_cnt--;
        end
      end
      if (!o_wb_stb) begin
        req_seen   = 1'b0;
        i_wb_stall = 1'b0;
      end else begin
        if (!req_seen) begin
          req_seen   = 1'b1;
          stall_left = slv_stall;
        end
        if (stall_left > 0) begin
          i_wb_stall = 1'b1;
          stall_left--;
        end else begin
          i_wb_stall = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    int nstb;
    int ncyc;
    i_rst = 1'b1; i_opcode = '0; i_funct3 = '0; i_y = '0; i_rs2_data = '0; i_pc = '0;
    i_wr_rd_en = 1'b0; i_rd_addr = '0; i_rd_data = '0; i_ce = 1'b0; i_stall = 1'b0;
    i_flush = 1'b0;
    repeat (3) tick();
    i_rst = 1'b0;

    // Reset state
    check("rst_pc", o_pc, PcReset);
    check("rst_ce", 32'(o_ce), 32'd0);
    check("rst_cyc", 32'(o_wb_cyc), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_load_data", o_load_data, 32'd0);

    // Non-memory op: one-cycle latency
    exp_res(32'h2000, 5'd5, 32'h1111_2222, 1'b0, 32'h0, 1'b0);
    issue(OpRtype, 3'b000, 32'h0, 32'h0, 32'h2000, 5'd5, 32'h1111_2222);
    wait_idle(n);
    check("alu_latency", 32'(n), 32'd0);
    tick();

    // SW, ack two cycles after request
    slv_stall = 0; slv_wait = 1;
    exp_bus(1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF, 1'b1);
    exp_res(32'h2004, 5'd0, 32'h100, 1'b0, 32'h0, 1'b0);
    issue(OpStore, Funct3Sw, 32'h100, 32'hDEAD_BEEF, 32'h2004, 5'd0, 32'h100);
    wait_idle(n);
    check("sw_stall_cycles", 32'(n), 32'd3);
    tick();

    // LB / LBU of top byte
    slv_rdata = 32'h80FF_0000;
    exp_bus(1'b0, 32'h100, 4'b1000, 32'h0, 1'b0);
    exp_res(32'h2008, 5'd6, 32'h103, 1'b0, 32'hFFFF_FF80, 1'b1);
    issue(OpLoad, Funct3Lb, 32'h103, 32'h0, 32'h2008, 5'd6, 32'h103);
    wait_idle(n);
    tick();
    exp_bus(1'b0, 32'h100, 4'b1000, 32'h0, 1'b0);
    exp_res(32'h200C, 5'd7, 32'h103, 1'b0, 32'h0000_0080, 1'b1);
    issue(OpLoad, Funct3Lbu, 32'h103, 32'h0, 32'h200C, 5'd7, 32'h103);
    wait_idle(n);
    tick();

    // SH upper half, SB lane 1, unsupported store funct3 as word
    exp_bus(1'b1, 32'h100, 4'b1100, 32'h1234_1234, 1'b1);
    exp_res(32'h2010, 5'd0, 32'h102, 1'b0, 32'h0, 1'b0);
    issue(OpStore, Funct3Sh, 32'h102, 32'h0000_1234, 32'h2010, 5'd0, 32'h102);
    wait_idle(n);
    tick();
    exp_bus(1'b1, 32'h100, 4'b0010, 32'hA5A5_A5A5, 1'b1);
    exp_res(32'h2014, 5'd0, 32'h101, 1'b0, 32'h0, 1'b0);
    issue(OpStore, Funct3Sb, 32'h101, 32'h0000_00A5, 32'h2014, 5'd0, 32'h101);
    wait_idle(n);
    tick();
    exp_bus(1'b1, 32'h104, 4'hF, 32'h0BAD_F00D, 1'b1);
    exp_res(32'h2018, 5'd0, 32'h104, 1'b0, 32'h0, 1'b0);
    issue(OpStore, 3'b100, 32'h104, 32'h0BAD_F00D, 32'h2018, 5'd0, 32'h104);
    wait_idle(n);
    tick();

    // Misaligned LW and unsupported-funct3 load: no bus cycle
    exp_res(32'h201C, 5'd8, 32'h101, 1'b1, 32'h0, 1'b0);
    issue(OpLoad, Funct3Lw, 32'h101, 32'h0, 32'h201C, 5'd8, 32'h101);
    check("lw_mis_no_cyc", 32'(o_wb_cyc), 32'd0);
    check("lw_mis_ce", 32'(o_ce), 32'd1);
    tick();
    exp_res(32'h2020, 5'd9, 32'h102, 1'b1, 32'h0, 1'b0);
    issue(OpLoad, 3'b011, 32'h102, 32'h0, 32'h2020, 5'd9, 32'h102);
    check("ld_f3_mis_no_cyc", 32'(o_wb_cyc), 32'd0);
    tick();

    // LH with slave stalling three cycles
    slv_stall = 3; slv_rdata = 32'hBEEF_1234;
    exp_bus(1'b0, 32'h200, 4'b1100, 32'h0, 1'b0);
    exp_res(32'h2024, 5'd10, 32'h202, 1'b0, 32'hFFFF_BEEF, 1'b1);
    issue(OpLoad, Funct3Lh, 32'h202, 32'h0, 32'h2024, 5'd10, 32'h202);
    n = 0; nstb = 0; ncyc = 0;
    while (o_stall && n < 50) begin
      if (o_wb_stb) nstb++;
      if (o_wb_cyc) ncyc++;
      tick();
      n++;
    end
    check("lh_stb_cycles", 32'(nstb), 32'd4);
    check("lh_cyc_cycles", 32'(ncyc), 32'd6);
    check("lh_stall_cycles", 32'(n), 32'd6);
    slv_stall = 0;
    tick();

    // LHU upper half, zero-extended
    slv_rdata = 32'h8001_0000;
    exp_bus(1'b0, 32'h100, 4'b1100, 32'h0, 1'b0);
    exp_res(32'h2028, 5'd11, 32'h102, 1'b0, 32'h0000_8001, 1'b1);
    issue(OpLoad, Funct3Lhu, 32'h102, 32'h0, 32'h2028, 5'd11, 32'h102);
    wait_idle(n);
    tick();

    // Flush while busy: cycle completes, result discarded
    slv_rdata = 32'h7777_7777;
    exp_bus(1'b0, 32'h300, 4'hF, 32'h0, 1'b0);
    issue(OpLoad, Funct3Lw, 32'h300, 32'h0, 32'h202C, 5'd12, 32'h300);
    i_flush = 1'b1;
    check("o_flush_pass", 32'(o_flush), 32'd1);
    tick();
    i_flush = 1'b0;
    wait_idle(n);
    check("busy_flush_ce", 32'(o_ce), 32'd0);
    check("busy_flush_cyc", 32'(o_wb_cyc), 32'd0);
    tick();
    check("busy_flush_ce_after", 32'(o_ce), 32'd0);

    // Flush in idle with a load: nothing issued
    i_opcode = '0; i_opcode[OpLoad] = 1'b1; i_funct3 = Funct3Lw; i_y = 32'h400;
    i_ce = 1'b1; i_flush = 1'b1;
    tick();
    i_ce = 1'b0; i_flush = 1'b0;
    check("idle_flush_cyc", 32'(o_wb_cyc), 32'd0);
    check("idle_flush_ce", 32'(o_ce), 32'd0);
    check("idle_flush_stall", 32'(o_stall), 32'd0);
    tick();

    // Writeback stall holds o_ce
    exp_res(32'h2030, 5'd13, 32'hCAFE_0001, 1'b0, 32'h0, 1'b0);
    issue(OpItype, 3'b000, 32'h0, 32'h0, 32'h2030, 5'd13, 32'hCAFE_0001);
    i_stall = 1'b1;
    tick();
    check("stall_hold_ce1", 32'(o_ce), 32'd1);
    check("stall_upstream", 32'(o_stall), 32'd1);
    tick();
    check("stall_hold_ce2", 32'(o_ce), 32'd1);
    i_stall = 1'b0;
    tick();
    check("stall_release_ce", 32'(o_ce), 32'd0);

    // Reset during a bus cycle; the late ack must be ignored
    slv_wait = 3; slv_rdata = 32'hFFFF_FFFF;
    exp_bus(1'b0, 32'h500, 4'hF, 32'h0, 1'b0);
    issue(OpLoad, Funct3Lw, 32'h500, 32'h0, 32'h2034, 5'd14, 32'h500);
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("rst_busy_cyc", 32'(o_wb_cyc), 32'd0);
    check("rst_busy_stb", 32'(o_wb_stb), 32'd0);
    check("rst_busy_ce", 32'(o_ce), 32'd0);
    check("rst_busy_stall", 32'(o_stall), 32'd0);
    repeat (5) tick();
    check("late_ack_ce", 32'(o_ce), 32'd0);
    check("late_ack_load_data", o_load_data, 32'd0);
    check("late_ack_pc", o_pc, PcReset);

    tick();
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("res_q_drained", 32'(res_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
